// File: rtl/serial_query_responder_pkg.sv
// Shared types and constants for the serial query responder: FSM states,
// default protocol bytes and small elaboration-time helpers.
package serial_query_responder_pkg;

  localparam logic [7:0] DEFAULT_CMD_BASE = 8'h78;
  localparam logic [7:0] DEFAULT_HEADER   = 8'hA5;
  localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LOAD,
    ST_START,
    ST_GAP,
    ST_WAIT
  } stateT;

  // A single channel still needs a one-bit select port.
  function automatic int chanWidth(input int nChan);
    return (nChan > 1) ? $clog2(nChan) : 1;
  endfunction

  function automatic logic isValidCmd(input logic [7:0] cmd, input logic [7:0] base,
                                      input int nChan);
    int offset;
    offset = int'({24'd0, cmd}) - int'({24'd0, base});
    return (offset >= 0) && (offset < nChan);
  endfunction

endpackage

// File: rtl/serial_query_responder_if.sv
// UART-side link of the responder: received-byte strobe in, transmit
// start/data out, transmitter busy back.
interface serial_query_responder_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  // Responder side: drives the transmitter, consumes the receiver.
  modport master (
    input  rx_data,
    input  rx_valid,
    input  tx_busy,
    output tx_start,
    output tx_data
  );

  // UART side: async_receiver / async_transmitter pair.
  modport slave (
    output rx_data,
    output rx_valid,
    output tx_busy,
    input  tx_start,
    input  tx_data
  );

endinterface

// File: rtl/serial_query_responder_frame_mux.sv
// Combinational frame byte select: header, channel index, snapshot sample
// bytes (LSB first), checksum; or the NAK byte for an unrecognised command.
module serial_query_responder_frame_mux
  import serial_query_responder_pkg::*;
#(
  parameter int         SAMPLE_W    = 16,
  parameter int         CNT_W       = 3,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter logic [7:0] NAK_BYTE    = DEFAULT_NAK_BYTE
) (
  input  logic [CNT_W-1:0]    byteCnt,
  input  logic                cmdValid,
  input  logic [7:0]          cmdIdx,
  input  logic [SAMPLE_W-1:0] shadow,
  input  logic [7:0]          checksum,
  output logic [7:0]          frameByte,
  output logic                isChecksumByte
);

  localparam int               N_BYTES  = SAMPLE_W / 8;
  localparam logic [CNT_W-1:0] CSUM_CNT = CNT_W'(N_BYTES + 2);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    frameByte      = NAK_BYTE;
    isChecksumByte = 1'b0;
    if (cmdValid) begin
      // Anything past the sample bytes is the checksum slot.
      frameByte = checksum;
      if (byteCnt == '0) begin
        frameByte = HEADER;
      end else if (byteCnt == CNT_W'(1)) begin
        frameByte = cmdIdx;
      end
      for (int b = 0; b < N_BYTES; b++) begin
        if (byteCnt == CNT_W'(b + 2)) begin
          frameByte = shadow[b*8 +: 8];
        end
      end
      isChecksumByte = CHECKSUM_EN && (byteCnt == CSUM_CNT);
    end
  end

endmodule

// File: rtl/serial_query_responder.sv
// UART query/response engine: decodes a one-byte channel query, snapshots the
// selected sample and returns it as a framed byte stream through the transmitter.
module serial_query_responder
  import serial_query_responder_pkg::*;
#(
  parameter int         N_CHAN      = 3,
  parameter int         SAMPLE_W    = 16,
  parameter logic [7:0] CMD_BASE    = DEFAULT_CMD_BASE,
  parameter logic [7:0] HEADER      = DEFAULT_HEADER,
  parameter logic [7:0] NAK_BYTE    = DEFAULT_NAK_BYTE,
  parameter bit         CHECKSUM_EN = 1'b1
) (
  input  logic                           CLK_50,
  input  logic                           iRSTN,
  serial_query_responder_if.master       uart,
  input  logic [N_CHAN*SAMPLE_W-1:0]     samples,
  output logic [chanWidth(N_CHAN)-1:0]   chan_sel,
  output logic                           frame_busy,
  output logic                           overrun
);

  localparam int               N_BYTES        = SAMPLE_W / 8;
  localparam int               CNT_W          = $clog2(N_BYTES + 3);
  localparam int               CHAN_W         = chanWidth(N_CHAN);
  localparam logic [CNT_W-1:0] LAST_VALID_CNT = CNT_W'(N_BYTES + 1 + int'(CHECKSUM_EN));

  stateT               state;
  stateT               stateNext;
  logic [7:0]          cmdReg;
  logic [7:0]          pendByte;
  logic                pendValid;
  logic [SAMPLE_W-1:0] shadow;
  logic [SAMPLE_W-1:0] selSample;
  logic [7:0]          checksum;
  logic [7:0]          frameByte;
  logic                isChecksumByte;
  logic [CNT_W-1:0]    byteCnt;
  logic [CNT_W-1:0]    lastCnt;
  logic                cmdValid;
  logic [7:0]          cmdIdx;

  logic acceptCmd;
  logic fromPending;
  logic startPulse;
  logic advance;
  logic finish;
  logic consumePending;
  logic captureRx;

  assign cmdValid = isValidCmd(cmdReg, CMD_BASE, N_CHAN);
  assign cmdIdx   = cmdReg - CMD_BASE;
  assign lastCnt  = cmdValid ? LAST_VALID_CNT : '0;

  always_comb begin
    selSample = '0;
    for (int k = 0; k < N_CHAN; k++) begin
      if (cmdIdx == 8'(k)) begin
        selSample = samples[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext   = state;
    acceptCmd   = 1'b0;
    fromPending = 1'b0;
    startPulse  = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pendValid) begin
          acceptCmd   = 1'b1;
          fromPending = 1'b1;
          stateNext   = ST_LATCH;
        end else if (uart.rx_valid) begin
          acceptCmd = 1'b1;
          stateNext = ST_LATCH;
        end
      end
      ST_LATCH: stateNext = ST_LOAD;
      ST_LOAD:  stateNext = ST_START;
      ST_START: begin
        if (!uart.tx_busy) begin
          startPulse = 1'b1;
          stateNext  = ST_GAP;
        end
      end
      // The transmitter raises busy one cycle after start; skip that blind cycle.
      ST_GAP:   stateNext = ST_WAIT;
      ST_WAIT: begin
        if (!uart.tx_busy) begin
          if (byteCnt != lastCnt) begin
            advance   = 1'b1;
            stateNext = ST_LOAD;
          end else if (pendValid) begin
            acceptCmd   = 1'b1;
            fromPending = 1'b1;
            stateNext   = ST_LATCH;
          end else begin
            finish    = 1'b1;
            stateNext = ST_IDLE;
          end
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // A received byte goes to the pending slot unless it is taken directly from IDLE.
  assign consumePending = acceptCmd && fromPending;
  assign captureRx      = uart.rx_valid && !(acceptCmd && !fromPending);

  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      cmdReg     <= '0;
      frame_busy <= 1'b0;
      pendByte   <= '0;
      pendValid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (acceptCmd) begin
        cmdReg     <= fromPending ? pendByte : uart.rx_data;
        frame_busy <= 1'b1;
      end else if (finish) begin
        frame_busy <= 1'b0;
      end

      if (captureRx) begin
        pendByte  <= uart.rx_data;
        pendValid <= 1'b1;
        if (pendValid && !consumePending) begin
          overrun <= 1'b1;
        end
      end else if (consumePending) begin
        pendValid <= 1'b0;
      end
    end
  end

  // NOTE: the shadow is a plain register, not a memory array, so it is reset with everything else.
  always_ff @(posedge CLK_50 or negedge iRSTN) begin
    if (!iRSTN) begin
      chan_sel      <= '0;
      shadow        <= '0;
      checksum      <= '0;
      byteCnt       <= '0;
      uart.tx_start <= 1'b0;
      uart.tx_data  <= '0;
    end else begin
      uart.tx_start <= startPulse;

      if (state == ST_LATCH) begin
        if (cmdValid) begin
          chan_sel <= cmdIdx[CHAN_W-1:0];
          shadow   <= selSample;
        end
        checksum <= '0;
        byteCnt  <= '0;
      end

      if (state == ST_LOAD) begin
        uart.tx_data <= frameByte;
        if (!isChecksumByte) begin
          checksum <= checksum ^ frameByte;
        end
      end

      if (advance) begin
        byteCnt <= byteCnt + CNT_W'(1);
      end
    end
  end

  serial_query_responder_frame_mux #(
    .SAMPLE_W    (SAMPLE_W),
    .CNT_W       (CNT_W),
    .CHECKSUM_EN (CHECKSUM_EN),
    .HEADER      (HEADER),
    .NAK_BYTE    (NAK_BYTE)
  ) u_frame_mux (
    .byteCnt        (byteCnt),
    .cmdValid       (cmdValid),
    .cmdIdx         (cmdIdx),
    .shadow         (shadow),
    .checksum       (checksum),
    .frameByte      (frameByte),
    .isChecksumByte (isChecksumByte)
  );

endmodule

// File: tb/tb_serial_query_responder.sv
// Bench for serial_query_responder: transmitter model, byte logger and a
// frame-level reference model driven by directed and randomized queries.
module tb_serial_query_responder;

  localparam int N_CHAN         = 3;
  localparam int SAMPLE_W       = 16;
  localparam int TX_BUSY_CYCLES = 10;
  localparam int WAIT_BUDGET    = 2000;

  typedef logic [7:0] byteQ[$];

  logic                       CLK_50 = 1'b0;
  logic                       iRSTN  = 1'b0;
  logic [N_CHAN*SAMPLE_W-1:0] samples = '0;
  logic [1:0]                 chan_sel;
  logic                       frame_busy;
  logic                       overrun;

  int   testsRun       = 0;
  int   testsFailed    = 0;
  int   busyCnt        = 0;
  int   startWhileBusy = 0;
  int   doubleStart    = 0;
  logic prevStart      = 1'b0;
  logic [1:0] expChanSel = '0;
  byteQ txLog;

  serial_query_responder_if link();

  serial_query_responder #(
    .N_CHAN   (N_CHAN),
    .SAMPLE_W (SAMPLE_W)
  ) dut (
    .CLK_50     (CLK_50),
    .iRSTN      (iRSTN),
    .uart       (link),
    .samples    (samples),
    .chan_sel   (chan_sel),
    .frame_busy (frame_busy),
    .overrun    (overrun)
  );

  always #10 CLK_50 = ~CLK_50;

  // Transmitter: busy from the cycle after start, for TX_BUSY_CYCLES cycles; ignores reset.
  assign link.tx_busy = (busyCnt != 0);

  always @(posedge CLK_50) begin
    if (link.tx_start) begin
      txLog.push_back(link.tx_data);
      if (link.tx_busy) startWhileBusy++;
      if (prevStart) doubleStart++;
    end
    prevStart = link.tx_start;
    if (link.tx_start) busyCnt <= TX_BUSY_CYCLES;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end

  // Reference: the frame a command must produce, from the sample bus at command time.
  function automatic byteQ expectedFrame(input logic [7:0] cmd,
                                         input logic [N_CHAN*SAMPLE_W-1:0] snap);
    byteQ q;
    int k;
    logic [SAMPLE_W-1:0] s;
    logic [7:0] x;
    k = int'({24'd0, cmd}) - 'h78;
    if (k < 0 || k >= N_CHAN) begin
      q.push_back(8'h15);
      return q;
    end
    s = snap[k*SAMPLE_W +: SAMPLE_W];
    q.push_back(8'hA5);
    q.push_back(8'(k));
    for (int b = 0; b < SAMPLE_W / 8; b++) q.push_back(s[b*8 +: 8]);
    x = '0;
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
    return q;
  endfunction

  function automatic int firstDiff(input byteQ got, input byteQ exp);
    int n;
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp[i]) return i;
    return (got.size() == exp.size()) ? -1 : n;
  endfunction

  function automatic string fmtQ(input byteQ q);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic sendRx(input logic [7:0] b);
    @(negedge CLK_50);
    link.rx_data  = b;
    link.rx_valid = 1'b1;
    @(negedge CLK_50);
    link.rx_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int cycles;
    cycles = 0;
    while (frame_busy !== 1'b0 && cycles < WAIT_BUDGET) begin
      @(negedge CLK_50);
      cycles++;
    end
    testsRun++;
    if (frame_busy !== 1'b0) begin
      testsFailed++;
      $display("FAIL %s_timeout: frame_busy=%b after %0d cycles, required 0", name, frame_busy, cycles);
    end
  endtask

  task automatic test_reset();
    iRSTN = 1'b0;
    link.rx_valid = 1'b0;
    link.rx_data  = '0;
    repeat (3) @(negedge CLK_50);
    testsRun += 5;
    if (link.tx_start !== 1'b0) begin testsFailed++; $display("FAIL reset_tx_start: got %b required 0", link.tx_start); end
    if (link.tx_data !== 8'h00) begin testsFailed++; $display("FAIL reset_tx_data: got %h required 00", link.tx_data); end
    if (chan_sel !== 2'd0) begin testsFailed++; $display("FAIL reset_chan_sel: got %0d required 0", chan_sel); end
    if (frame_busy !== 1'b0) begin testsFailed++; $display("FAIL reset_frame_busy: got %b required 0", frame_busy); end
    if (overrun !== 1'b0) begin testsFailed++; $display("FAIL reset_overrun: got %b required 0", overrun); end
    iRSTN = 1'b1;
    repeat (2) @(negedge CLK_50);
  endtask

  task automatic test_single_query();
    byteQ exp;
    int d;
    @(negedge CLK_50);
    samples = {16'h0000, 16'h1234, 16'h0000};
    exp = expectedFrame(8'h79, samples);
    txLog.delete();
    link.rx_data  = 8'h79;
    link.rx_valid = 1'b1;
    @(negedge CLK_50);
    link.rx_valid = 1'b0;
    @(negedge CLK_50);
    testsRun++;
    if (chan_sel !== 2'd1) begin testsFailed++; $display("FAIL latency_chan_sel: got %0d required 1 at t+2", chan_sel); end
    @(negedge CLK_50);
    testsRun++;
    if (link.tx_start !== 1'b0) begin testsFailed++; $display("FAIL latency_early_start: got %b required 0 at t+3", link.tx_start); end
    @(negedge CLK_50);
    testsRun += 2;
    if (link.tx_start !== 1'b1) begin testsFailed++; $display("FAIL latency_start: got %b required 1 at t+4", link.tx_start); end
    if (link.tx_data !== exp[0]) begin testsFailed++; $display("FAIL latency_header: got %h required %h", link.tx_data, exp[0]); end
    waitIdle("single");
    testsRun += 2;
    if (link.tx_busy !== 1'b0) begin testsFailed++; $display("FAIL single_busy_at_done: tx_busy=%b required 0", link.tx_busy); end
    d = firstDiff(txLog, exp);
    if (d >= 0) begin testsFailed++; $display("FAIL single_frame: byte %0d, got %s required %s", d, fmtQ(txLog), fmtQ(exp)); end
    expChanSel = 2'd1;
  endtask

  task automatic test_bad_command();
    byteQ exp;
    int d;
    txLog.delete();
    exp = expectedFrame(8'h41, samples);
    sendRx(8'h41);
    waitIdle("nak");
    testsRun += 2;
    d = firstDiff(txLog, exp);
    if (d >= 0) begin testsFailed++; $display("FAIL nak_frame: byte %0d, got %s required %s", d, fmtQ(txLog), fmtQ(exp)); end
    if (chan_sel !== expChanSel) begin testsFailed++; $display("FAIL nak_chan_sel: got %0d required %0d", chan_sel, expChanSel); end
  endtask

  task automatic test_back_to_back();
    byteQ exp;
    byteQ second;
    int d;
    samples = {16'hC0DE, 16'h5A5A, 16'hBEEF};
    txLog.delete();
    exp = expectedFrame(8'h78, samples);
    second = expectedFrame(8'h7A, samples);
    foreach (second[i]) exp.push_back(second[i]);
    sendRx(8'h78);
    repeat (20) @(negedge CLK_50);
    sendRx(8'h7A);
    waitIdle("b2b");
    testsRun += 3;
    d = firstDiff(txLog, exp);
    if (d >= 0) begin testsFailed++; $display("FAIL b2b_frames: byte %0d, got %s required %s", d, fmtQ(txLog), fmtQ(exp)); end
    if (overrun !== 1'b0) begin testsFailed++; $display("FAIL b2b_overrun: got %b required 0", overrun); end
    if (chan_sel !== 2'd2) begin testsFailed++; $display("FAIL b2b_chan_sel: got %0d required 2", chan_sel); end
    expChanSel = 2'd2;
  endtask

  task automatic test_overrun();
    byteQ exp;
    byteQ second;
    int d;
    samples = {16'h1357, 16'h2468, 16'h9ACE};
    txLog.delete();
    exp = expectedFrame(8'h78, samples);
    second = expectedFrame(8'h7A, samples);
    foreach (second[i]) exp.push_back(second[i]);
    sendRx(8'h78);
    repeat (10) @(negedge CLK_50);
    sendRx(8'h79);
    repeat (10) @(negedge CLK_50);
    sendRx(8'h7A);
    waitIdle("overrun");
    testsRun += 2;
    d = firstDiff(txLog, exp);
    if (d >= 0) begin testsFailed++; $display("FAIL overrun_frames: byte %0d, got %s required %s", d, fmtQ(txLog), fmtQ(exp)); end
    if (overrun !== 1'b1) begin testsFailed++; $display("FAIL overrun_flag: got %b required 1", overrun); end
    expChanSel = 2'd2;
  endtask

  task automatic test_snapshot();
    byteQ exp;
    int d;
    int cycles;
    samples = {16'h0000, 16'h0000, 16'h00FF};
    txLog.delete();
    exp = expectedFrame(8'h78, samples);
    sendRx(8'h78);
    cycles = 0;
    while (txLog.size() < 1 && cycles < WAIT_BUDGET) begin
      @(negedge CLK_50);
      cycles++;
    end
    samples[15:0] = 16'hAB00;
    waitIdle("snapshot");
    testsRun++;
    d = firstDiff(txLog, exp);
    if (d >= 0) begin testsFailed++; $display("FAIL snapshot_frame: byte %0d, got %s required %s", d, fmtQ(txLog), fmtQ(exp)); end
    expChanSel = 2'd0;
  endtask

  task automatic test_reset_midframe();
    int cycles;
    int logged;
    samples = {16'h0000, 16'h7777, 16'h0000};
    txLog.delete();
    sendRx(8'h79);
    cycles = 0;
    while (txLog.size() < 2 && cycles < WAIT_BUDGET) begin
      @(negedge CLK_50);
      cycles++;
    end
    testsRun++;
    if (txLog.size() < 2) begin testsFailed++; $display("FAIL midreset_progress: got %0d bytes required 2", txLog.size()); end
    testsRun++;
    if (chan_sel !== 2'd1) begin testsFailed++; $display("FAIL midreset_pre_chan_sel: got %0d required 1", chan_sel); end
    iRSTN = 1'b0;
    #1;
    testsRun += 4;
    if (link.tx_start !== 1'b0) begin testsFailed++; $display("FAIL midreset_tx_start: got %b required 0", link.tx_start); end
    if (chan_sel !== 2'd0) begin testsFailed++; $display("FAIL midreset_chan_sel: got %0d required 0", chan_sel); end
    if (frame_busy !== 1'b0) begin testsFailed++; $display("FAIL midreset_frame_busy: got %b required 0", frame_busy); end
    if (overrun !== 1'b0) begin testsFailed++; $display("FAIL midreset_overrun: got %b required 0", overrun); end
    @(negedge CLK_50);
    iRSTN = 1'b1;
    logged = txLog.size();
    repeat (40) @(negedge CLK_50);
    testsRun++;
    if (txLog.size() != logged) begin testsFailed++; $display("FAIL midreset_no_start: got %0d bytes required %0d", txLog.size(), logged); end
    expChanSel = 2'd0;
  endtask

  task automatic test_random_queries();
    byteQ exp;
    logic [7:0] cmd;
    int d;
    for (int n = 0; n < 20; n++) begin
      samples[31:0]  = $urandom();
      samples[47:32] = 16'($urandom());
      if ($urandom_range(0, 3) != 0) cmd = 8'h78 + 8'($urandom_range(0, 2));
      else cmd = 8'($urandom());
      exp = expectedFrame(cmd, samples);
      if (cmd >= 8'h78 && cmd < 8'h7B) expChanSel = 2'(cmd - 8'h78);
      txLog.delete();
      sendRx(cmd);
      waitIdle("random");
      testsRun += 2;
      d = firstDiff(txLog, exp);
      if (d >= 0) begin testsFailed++; $display("FAIL random_frame cmd=%h: byte %0d, got %s required %s", cmd, d, fmtQ(txLog), fmtQ(exp)); end
      if (chan_sel !== expChanSel) begin testsFailed++; $display("FAIL random_chan_sel cmd=%h: got %0d required %0d", cmd, chan_sel, expChanSel); end
    end
  endtask

  task automatic test_start_protocol();
    testsRun += 2;
    if (startWhileBusy != 0) begin testsFailed++; $display("FAIL start_while_busy: got %0d required 0", startWhileBusy); end
    if (doubleStart != 0) begin testsFailed++; $display("FAIL start_pulse_width: got %0d long pulses required 0", doubleStart); end
  endtask

  initial begin
    link.rx_data  = '0;
    link.rx_valid = 1'b0;
    test_reset();
    test_single_query();
    test_bad_command();
    test_back_to_back();
    test_overrun();
    test_snapshot();
    test_reset_midframe();
    test_random_queries();
    test_start_protocol();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
